// File: rtl/arm_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : arm_regfile_sb
// Brief    : Scoreboarded register file: two combinational read ports with
//            optional write bypass, two write ports, per-register pending bits.
// Revision : 1.0 - initial release
// ============================================================================
module arm_regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic              busy1,
    output logic              busy2,
    input  logic              wb_en0,
    input  logic [ADDR_W-1:0] wb_dest0,
    input  logic [DATA_W-1:0] wb_data0,
    input  logic              wb_en1,
    input  logic [ADDR_W-1:0] wb_dest1,
    input  logic [DATA_W-1:0] wb_data1,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              flush,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_pend_nxt;
    logic [ADDR_W:0]     r_pend_cnt;
    logic [ADDR_W:0]     w_cnt_nxt;

    logic w_hit0_1, w_hit1_1, w_hit0_2, w_hit1_2;
    logic w_hit1, w_hit2;

    // Port 0 is applied last so it wins an address collision with port 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (wb_en1) r_regs[wb_dest1] <= wb_data1;
            if (wb_en0) r_regs[wb_dest0] <= wb_data0;
        end
    end

    // Issue is applied after flush and write clears so a new destination stays tracked.
    always_comb begin
        w_pend_nxt = r_pend;
        if (flush)    w_pend_nxt = '0;
        if (wb_en0)   w_pend_nxt[wb_dest0] = 1'b0;
        if (wb_en1)   w_pend_nxt[wb_dest1] = 1'b0;
        if (issue_en) w_pend_nxt[issue_dest] = 1'b1;
        w_cnt_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_pend_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= w_cnt_nxt;
        end
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_hit0_1 = wb_en0 && (wb_dest0 == src1);
            assign w_hit1_1 = wb_en1 && (wb_dest1 == src1);
            assign w_hit0_2 = wb_en0 && (wb_dest0 == src2);
            assign w_hit1_2 = wb_en1 && (wb_dest1 == src2);
        end else begin : g_no_bypass
            assign w_hit0_1 = 1'b0;
            assign w_hit1_1 = 1'b0;
            assign w_hit0_2 = 1'b0;
            assign w_hit1_2 = 1'b0;
        end
    endgenerate

    assign w_hit1 = w_hit0_1 | w_hit1_1;
    assign w_hit2 = w_hit0_2 | w_hit1_2;

    assign reg1 = w_hit0_1 ? wb_data0 : (w_hit1_1 ? wb_data1 : r_regs[src1]);
    assign reg2 = w_hit0_2 ? wb_data0 : (w_hit1_2 ? wb_data1 : r_regs[src2]);

    assign busy1    = r_pend[src1] & ~w_hit1;
    assign busy2    = r_pend[src2] & ~w_hit2;
    assign pend_cnt = r_pend_cnt;

endmodule
`default_nettype wire
